// File: rtl/ode_param_memory.sv
// Purpose : word memory responder on the shared ODE parameter bus, plus a side load port for preloading.
// Latency : read data and rd_valid appear after the 2nd rising edge that samples a stable read address.
// Backpr. : none; the bus is released in the same cycle mem_wr_enable rises, and a load-port write wins over a bus write.
//
// Ports:
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   address_bus[63:0]            word address from the bus initiator
//   data_bus[DATA_W-1:0]         inout; driven here only while serving a read, else Z
//   mem_wr_enable                initiator is driving data_bus for a write this cycle
//   init_we/init_addr/init_data  load-port write
//   rd_valid                     data_bus holds mem[address_bus]
//   err_oob                      1-cycle pulse: sampled access with address_bus >= DEPTH
//   err_coll                     1-cycle pulse: bus write dropped because of init_we
module ode_param_memory #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              mem_wr_enable,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              rd_valid,
    output logic              err_oob,
    output logic              err_coll
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DRIVE = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [63:0]       addr_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic bus_oob;
    logic q_oob;
    logic addr_same;
    logic drive_en;
    logic init_ok;

    // A single unsigned compare over the full 64-bit address covers both
    // non-zero upper bits and low bits beyond the last stored word.
    assign bus_oob   = address_bus >= 64'(DEPTH);
    assign q_oob     = addr_q >= 64'(DEPTH);
    assign addr_same = address_bus == addr_q;
    assign init_ok   = {1'b0, init_addr} < DEPTH_W;

    // Decoded combinationally from mem_wr_enable so the bus is released in
    // the very cycle an initiator starts driving write data.
    assign drive_en = (state == DRIVE) && !mem_wr_enable;
    assign data_bus = drive_en ? rd_q : {DATA_W{1'bz}};

    // Control path. addr_q samples the bus every edge, so in ADDR/DRIVE
    // addr_same means "the address has been stable since the last edge".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            rd_q     <= '0;
            rd_valid <= 1'b0;
            err_oob  <= 1'b0;
            err_coll <= 1'b0;
        end else begin
            addr_q   <= address_bus;
            rd_valid <= 1'b0;
            err_oob  <= 1'b0;
            err_coll <= 1'b0;

            // Registered read of the word latched on the previous edge;
            // out-of-range reads return zero.
            if (state == ADDR) begin
                rd_q <= q_oob ? '0 : mem[addr_q[ADDR_W-1:0]];
            end

            if (mem_wr_enable) begin
                // Every write edge is a sampled access, whatever the state.
                state    <= WRITE;
                err_oob  <= bus_oob;
                err_coll <= init_we;
            end else begin
                case (state)
                    ADDR, DRIVE: begin
                        if (addr_same) begin
                            state    <= DRIVE;
                            rd_valid <= 1'b1;
                        end else begin
                            state   <= ADDR;
                            err_oob <= bus_oob;
                        end
                    end
                    default: begin
                        // IDLE or end of a write burst: start a new read.
                        state   <= ADDR;
                        err_oob <= bus_oob;
                    end
                endcase
            end
        end
    end

    // Storage is deliberately not reset so parameters survive a reset.
    // The load port has priority; a colliding bus write is dropped.
    always_ff @(posedge clk) begin
        if (init_we) begin
            if (init_ok) begin
                mem[init_addr] <= init_data;
            end
        end else if (mem_wr_enable && !bus_oob) begin
            mem[address_bus[ADDR_W-1:0]] <= data_bus;
        end
    end

endmodule

// File: tb/tb_ode_param_memory.sv
module tb_ode_param_memory;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    localparam logic [63:0] W8 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] W3 = 64'h0000_0000_0000_3333;
    localparam logic [63:0] W4 = 64'h4444_0000_0000_0004;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [63:0]       address_bus;
    wire  [DATA_W-1:0] data_bus;
    logic              mem_wr_enable;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              rd_valid;
    logic              err_oob;
    logic              err_coll;

    // Bench side of the shared bus: write data, or an all-zero keeper
    // whenever the responder is expected to have released the bus.
    logic              tb_drv_en;
    logic [DATA_W-1:0] tb_dat;
    assign data_bus = tb_drv_en ? tb_dat : {DATA_W{1'bz}};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ode_param_memory #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address_bus  (address_bus),
        .data_bus     (data_bus),
        .mem_wr_enable(mem_wr_enable),
        .init_we      (init_we),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .rd_valid     (rd_valid),
        .err_oob      (err_oob),
        .err_coll     (err_coll)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic keep();
        tb_drv_en = 1'b1;
        tb_dat    = '0;
    endtask

    // New read address held for two edges: released after the first,
    // data and rd_valid after the second.
    task automatic do_read(input logic [63:0] addr, input logic [63:0] exp, input logic exp_oob);
        address_bus   = addr;
        mem_wr_enable = 1'b0;
        keep();
        tick();
        check($sformatf("rd%0h_valid_e1", addr), rd_valid, 0);
        check($sformatf("rd%0h_released_e1", addr), data_bus, 0);
        check($sformatf("rd%0h_oob_e1", addr), err_oob, exp_oob);
        check($sformatf("rd%0h_coll_e1", addr), err_coll, 0);
        tb_drv_en = 1'b0;
        tick();
        check($sformatf("rd%0h_valid_e2", addr), rd_valid, 1);
        check($sformatf("rd%0h_data_e2", addr), data_bus, exp);
        check($sformatf("rd%0h_oob_e2", addr), err_oob, 0);
    endtask

    // Single-cycle bus write; the bus must carry exactly the bench's data.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] dat,
                            input logic exp_oob, input logic exp_coll);
        address_bus   = addr;
        mem_wr_enable = 1'b1;
        tb_drv_en     = 1'b1;
        tb_dat        = dat;
        #1;
        check($sformatf("wr%0h_bus_clean", addr), data_bus, dat);
        tick();
        check($sformatf("wr%0h_oob", addr), err_oob, exp_oob);
        check($sformatf("wr%0h_coll", addr), err_coll, exp_coll);
        check($sformatf("wr%0h_valid", addr), rd_valid, 0);
        mem_wr_enable = 1'b0;
        keep();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] ld_a [5];
        logic [DATA_W-1:0] ld_d [5];
        ld_a[0] = 5'd0; ld_d[0] = 64'h10;
        ld_a[1] = 5'd1; ld_d[1] = 64'd5;
        ld_a[2] = 5'd3; ld_d[2] = W3;
        ld_a[3] = 5'd4; ld_d[3] = W4;
        ld_a[4] = 5'd8; ld_d[4] = W8;

        reset_n       = 1'b0;
        address_bus   = '0;
        mem_wr_enable = 1'b0;
        init_we       = 1'b0;
        init_addr     = '0;
        init_data     = '0;
        keep();
        #12;
        check("rst_valid", rd_valid, 0);
        check("rst_oob", err_oob, 0);
        check("rst_coll", err_coll, 0);
        check("rst_released", data_bus, 0);
        #10;
        reset_n     = 1'b1;
        address_bus = 64'd7;

        // Preload through the side port while the bus reads an unrelated word.
        for (int i = 0; i < 5; i++) begin
            init_we   = 1'b1;
            init_addr = ld_a[i];
            init_data = ld_d[i];
            tick();
        end
        init_we = 1'b0;

        // Load-port data read over the bus with 2-edge latency.
        do_read(64'd0, 64'h10, 1'b0);

        // One-cycle bus write, then read it back.
        do_write(64'd0, 64'h9, 1'b0, 1'b0);
        do_read(64'd0, 64'h9, 1'b0);

        // Alternating reads, address changing every 2 cycles.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) do_read(64'd3, W3, 1'b0);
            else            do_read(64'd4, W4, 1'b0);
        end

        // Out of range: low-bit overflow and non-zero upper bits.
        do_read(64'd40, 64'h0, 1'b1);
        do_write(64'd40, 64'hBAD, 1'b1, 1'b0);
        do_read(64'd8, W8, 1'b0);
        do_read(64'h1_0000_0001, 64'h0, 1'b1);
        do_read(64'd0, 64'h9, 1'b0);

        // Load port and bus write on the same edge: load port wins.
        init_we   = 1'b1;
        init_addr = 5'd2;
        init_data = 64'hAAAA;
        do_write(64'd2, 64'h5555, 1'b0, 1'b1);
        init_we = 1'b0;
        do_read(64'd2, 64'hAAAA, 1'b0);

        // Asynchronous reset while driving a read.
        do_read(64'd1, 64'd5, 1'b0);
        keep();
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", rd_valid, 0);
        check("rst_mid_released", data_bus, 0);
        #3;
        reset_n = 1'b1;
        do_read(64'd0, 64'h9, 1'b0);
        do_read(64'd2, 64'hAAAA, 1'b0);
        do_read(64'd8, W8, 1'b0);
        do_read(64'd1, 64'd5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
